inst_fetch_ctrl: RTL

//  Sequences the instruction memory: owns the PC, drives the word address, and captures the

---
 rtl/riscie_pkg.sv | 25 ++
 rtl/inst_fetch_ctrl_if.sv | 23 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/inst_fetch_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/riscie_pkg.sv
// Shared fetch-path definitions: data width, reset PC, FSM encoding and FIFO entry layout.
package riscie_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 64;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits of a byte address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-memory and decode-side bus of the fetch controller.
// master = fetch controller, slave = memory/decode environment.
interface inst_fetch_ctrl_if;
  import riscie_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  modport master (
    output imem_addr, if_valid, if_pc, if_instr,
    input  imem_data, if_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_pc, if_instr,
    output imem_data, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush. When empty, the read port keeps
// presenting the last head that was visible so downstream never sees stale
// or uninitialised storage.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] head;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = empty ? hold_q : head;

  // Pointer update; flush wins over any push/pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer and last-visible-head registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (!empty) hold_q <= head;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, addresses instMemory, captures
// its combinational read data into the prefetch FIFO and hands {pc, instr}
// to decode. Supports redirect (flush + new PC) and halt.
// Optional feature: define FETCH_ALIGN_CHK_EN to trap misaligned redirect
// targets into a sticky fetch_err and HALTED; otherwise the low target bits
// are dropped and fetch_err reads 0.
module inst_fetch_ctrl
  import riscie_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter int unsigned     ADDR_BITS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              busy,
  output logic              fetch_err,
  inst_fetch_ctrl_if.master bus
);

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               busy_q;
  logic               push;
  logic               pop;
  logic               flush;
  logic               fifo_full;
  logic               fifo_empty;
  fetch_entry_t       wr_entry;
  fetch_entry_t       head;
  logic [ENTRY_W-1:0] head_raw;

  assign pop      = !fifo_empty && bus.if_ready;
  assign wr_entry = '{pc: pc_q, instr: bus.imem_data};
  assign head     = fetch_entry_t'(head_raw);

  assign bus.imem_addr = XLEN'(pc_q[ADDR_BITS+1:2]);
  assign bus.if_valid  = !fifo_empty;
  assign bus.if_pc     = head.pc;
  assign bus.if_instr  = head.instr;
  assign busy          = busy_q;

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q, err_d;
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Next state, next PC and FIFO control; redirect overrides the normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (!fifo_full || pop) begin
          push = 1'b1;
          pc_d = pc_q + XLEN'(4);
        end
      end
      ST_HALTED: begin
        if (start) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect && (state_q != ST_IDLE)) begin
      push  = 1'b0;
      flush = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        pc_d    = pc_q;
        err_d   = 1'b1;
        state_d = ST_HALTED;
      end else begin
        pc_d = word_align(redirect_pc);
      end
`else
      pc_d = word_align(redirect_pc);
`endif
    end
  end

  // State, PC and busy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy_q  <= (state_d == ST_FETCH);
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  // Sticky misalignment flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_entry),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
